// File: rtl/data_mem_cipher_pkg.sv
// Shared state codes and owner ids for the data-memory cipher arbiter.
// Imported by data_mem_rr_pick and data_mem_cipher_arbiter.
package data_mem_cipher_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam logic OWNER_WR = 1'b0;
  localparam logic OWNER_RD = 1'b1;

  function automatic logic other_owner(
    input logic owner
  );
    return (owner == OWNER_WR) ? OWNER_RD
                               : OWNER_WR;
  endfunction

endpackage

// File: rtl/data_mem_rr_pick.sv
// Two-way store/load picker for the cipher core; round-robin by default,
// fixed load-first priority when DATA_MEM_RD_PRIORITY_EN is defined.
module data_mem_rr_pick
  import data_mem_cipher_pkg::*;
(
  input  logic wr_req,
  input  logic rd_req,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_owner
);

  assign grant_valid = wr_req | rd_req;

`ifdef DATA_MEM_RD_PRIORITY_EN

  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    grant_owner = OWNER_WR;
    unique case (1'b1)
      rd_req:  grant_owner = OWNER_RD;
      default: grant_owner = OWNER_WR;
    endcase
  end

`else

  always_comb begin
    grant_owner = OWNER_WR;
    unique case (1'b1)
      (wr_req & rd_req):
        grant_owner = other_owner(last_owner);
      (rd_req & ~wr_req):
        grant_owner = OWNER_RD;
      default:
        grant_owner = OWNER_WR;
    endcase
  end

`endif

endmodule

// File: rtl/data_mem_cipher_arbiter.sv
// Shares one data-memory cipher core between store (encrypt) and load
// (decrypt) paths; DATA_MEM_RD_PRIORITY_EN selects fixed load priority.
module data_mem_cipher_arbiter
  import data_mem_cipher_pkg::*;
#(
  parameter int DATA_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_req,
  input  logic [DATA_SIZE-1:0] wr_din,
  output logic                 wr_done,
  output logic [DATA_SIZE-1:0] wr_dout,
  input  logic                 rd_req,
  input  logic [DATA_SIZE-1:0] rd_din,
  output logic                 rd_done,
  output logic [DATA_SIZE-1:0] rd_dout,
  input  logic                 core_initializing,
  input  logic                 core_busy,
  input  logic [DATA_SIZE-1:0] core_dout,
  output logic                 core_start,
  output logic                 core_decrypt,
  output logic [DATA_SIZE-1:0] core_din,
  output logic                 timeout_err
);

  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LIMIT =
    WDW'(TIMEOUT_CYCLES);

  state_t st_q;
  state_t st_d;

  logic                 owner_q;
  logic                 owner_d;
  logic                 last_q;
  logic                 last_d;
  logic [DATA_SIZE-1:0] op_q;
  logic [DATA_SIZE-1:0] op_d;
  logic [DATA_SIZE-1:0] wr_dout_q;
  logic [DATA_SIZE-1:0] wr_dout_d;
  logic [DATA_SIZE-1:0] rd_dout_q;
  logic [DATA_SIZE-1:0] rd_dout_d;
  logic                 wr_done_q;
  logic                 wr_done_d;
  logic                 rd_done_q;
  logic                 rd_done_d;
  logic [WDW-1:0]       wdog_q;
  logic [WDW-1:0]       wdog_d;
  logic                 err_q;
  logic                 err_d;

  logic           grant_valid;
  logic           grant_owner;
  logic           grant_take;
  logic [WDW-1:0] wdog_inc;
  logic           wdog_hit;
  logic           op_end;

  data_mem_rr_pick u_pick (
    .wr_req      (wr_req),
    .rd_req      (rd_req),
    .last_owner  (last_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  assign grant_take = (st_q == ST_IDLE)
                    & ~core_initializing
                    & grant_valid;

  assign wdog_inc = wdog_q + WDW'(1);

  assign wdog_hit = (st_q == ST_WAIT)
                  & core_busy
                  & (wdog_inc == WD_LIMIT);

  // Timeout ends the op too, so the requester is always released.
  assign op_end = (st_q == ST_WAIT)
                & (~core_busy | wdog_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= ST_IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE: begin
        if (grant_take) begin
          st_d = ST_START;
        end
      end
      ST_START: begin
        st_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (op_end) begin
          st_d = ST_DONE;
        end
      end
      ST_DONE: begin
        st_d = ST_IDLE;
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    core_start   = (st_q == ST_START);
    core_decrypt = owner_q;
    core_din     = op_q;
    wr_done      = wr_done_q;
    rd_done      = rd_done_q;
    wr_dout      = wr_dout_q;
    rd_dout      = rd_dout_q;
    timeout_err  = err_q;
  end

  always_comb begin
    owner_d = owner_q;
    op_d    = op_q;
    if (grant_take) begin
      owner_d = grant_owner;
      op_d    = (grant_owner == OWNER_RD)
              ? rd_din
              : wr_din;
    end
  end

  always_comb begin
    wdog_d = wdog_q;
    err_d  = err_q;
    unique case (1'b1)
      (st_q == ST_START): begin
        wdog_d = '0;
      end
      (st_q == ST_WAIT) && core_busy: begin
        wdog_d = wdog_inc;
        err_d  = err_q | wdog_hit;
      end
      default: begin
        wdog_d = wdog_q;
      end
    endcase
  end

  // Result is captured as busy falls so dout is valid with done.
  always_comb begin
    wr_dout_d = wr_dout_q;
    rd_dout_d = rd_dout_q;
    wr_done_d = 1'b0;
    rd_done_d = 1'b0;
    if (op_end) begin
      if (owner_q == OWNER_RD) begin
        rd_dout_d = core_dout;
        rd_done_d = 1'b1;
      end else begin
        wr_dout_d = core_dout;
        wr_done_d = 1'b1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (st_q == ST_DONE) begin
      last_d = owner_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWNER_WR;
      op_q    <= '0;
      last_q  <= OWNER_RD;
    end else begin
      owner_q <= owner_d;
      op_q    <= op_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_dout_q <= '0;
      rd_dout_q <= '0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      wr_dout_q <= wr_dout_d;
      rd_dout_q <= rd_dout_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
    end
  end

endmodule

// File: tb/tb_data_mem_cipher_arbiter.sv
// Directed plus randomized bench for data_mem_cipher_arbiter with a
// transaction-level model and a behavioural cipher core.
module tb_data_mem_cipher_arbiter;

  localparam int TO = 4;
  localparam logic [31:0] KE = 32'hD8CA_5679;
  localparam logic [31:0] KD = 32'h0F0F_3C3C;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_req, rd_req;
  logic [31:0] wr_din, rd_din;
  logic        wr_done, rd_done;
  logic [31:0] wr_dout, rd_dout;
  logic        core_initializing, core_busy;
  logic [31:0] core_dout;
  logic        core_start, core_decrypt;
  logic [31:0] core_din;
  logic        timeout_err;

  always #5 clk = ~clk;

  data_mem_cipher_arbiter #(
    .DATA_SIZE      (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .wr_req            (wr_req),
    .wr_din            (wr_din),
    .wr_done           (wr_done),
    .wr_dout           (wr_dout),
    .rd_req            (rd_req),
    .rd_din            (rd_din),
    .rd_done           (rd_done),
    .rd_dout           (rd_dout),
    .core_initializing (core_initializing),
    .core_busy         (core_busy),
    .core_dout         (core_dout),
    .core_start        (core_start),
    .core_decrypt      (core_decrypt),
    .core_din          (core_din),
    .timeout_err       (timeout_err)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  // inputs as seen at the last edge
  logic        p_rst, p_init, p_wr, p_rd;
  logic [31:0] p_wdin, p_rdin, p_cdout;
  // transaction model
  bit          m_idle, m_op, m_own, m_to, m_last, m_err;
  int          m_done_k;
  logic [31:0] m_din, m_wdout, m_rdout;
  int          cur_n;
  // core model
  int          busy_left;
  bit          stuck;
  logic [31:0] res_pend;
  int          fix_n;
  // requesters
  int          wr_mode, rd_mode;
  bit          rand_init;
  // logs
  int          k;
  int          start_k, wr_done_k, rd_done_k;
  int          wr_done_n, rd_done_n;
  int          owner_log[$];

  task automatic step();
    bit e_start, e_wd, e_rdn;
    logic [31:0] res;
    p_rst = reset; p_init = core_initializing;
    p_wr = wr_req; p_rd = rd_req;
    p_wdin = wr_din; p_rdin = rd_din;
    p_cdout = core_dout;
    @(posedge clk); #1;
    k++;
    e_start = 0; e_wd = 0; e_rdn = 0;
    if (p_rst) begin
      m_idle = 1; m_op = 0; m_err = 0;
      m_wdout = 0; m_rdout = 0; m_last = 1;
    end else begin
      e_start = m_idle && !p_init && (p_wr || p_rd);
      if (m_op && k == m_done_k + 1) begin
        m_op = 0; m_idle = 1;
      end
      if (e_start) begin
`ifdef DATA_MEM_RD_PRIORITY_EN
        m_own = p_rd;
`else
        m_own = (p_wr && p_rd) ? !m_last : p_rd;
`endif
        m_din = m_own ? p_rdin : p_wdin;
        m_idle = 0; m_op = 1;
        cur_n = (fix_n >= 0) ? fix_n : $urandom_range(0, 5);
        if (stuck) cur_n = 1000;
        m_to = (cur_n >= TO);
        m_done_k = k + (m_to ? TO + 1 : cur_n + 2);
      end
      if (m_op && k == m_done_k) begin
        e_wd = !m_own; e_rdn = m_own;
        if (m_to) m_err = 1;
        res = m_to ? p_cdout : (m_din ^ (m_own ? KD : KE));
        if (m_own) m_rdout = res;
        else m_wdout = res;
        m_last = m_own;
      end
    end
    chk("core_start", core_start, e_start);
    chk("wr_done", wr_done, e_wd);
    chk("rd_done", rd_done, e_rdn);
    chk("wr_dout", wr_dout, m_wdout);
    chk("rd_dout", rd_dout, m_rdout);
    chk("timeout_err", timeout_err, m_err);
    if (m_op) begin
      chk("core_decrypt", core_decrypt, m_own);
      chk("core_din", core_din, m_din);
    end
    if (core_start) begin
      start_k = k;
      owner_log.push_back(int'(core_decrypt));
    end
    if (wr_done) begin wr_done_k = k; wr_done_n++; end
    if (rd_done) begin rd_done_k = k; rd_done_n++; end
    // behavioural core
    if (stuck || busy_left > 0) begin
      core_busy = 1; core_dout = $urandom;
      if (busy_left > 0) busy_left--;
    end else begin
      core_busy = 0; core_dout = res_pend;
    end
    if (core_start) begin
      busy_left = cur_n;
      res_pend = core_din ^ (core_decrypt ? KD : KE);
    end
    // requesters
    if (wr_done) begin
      wr_req = 0; wr_din = $urandom;
    end else if (!wr_req && (wr_mode == 1 ||
               (wr_mode == 2 && $urandom_range(0, 9) < 3))) begin
      wr_req = 1; wr_din = $urandom;
    end
    if (rd_done) begin
      rd_req = 0; rd_din = $urandom;
    end else if (!rd_req && (rd_mode == 1 ||
               (rd_mode == 2 && $urandom_range(0, 9) < 3))) begin
      rd_req = 1; rd_din = $urandom;
    end
    if (rand_init && $urandom_range(0, 19) == 0)
      core_initializing = ~core_initializing;
  endtask

  task automatic do_reset();
    wr_req = 0; rd_req = 0;
    reset = 1; busy_left = 0; stuck = 0;
    repeat (2) step();
    reset = 0;
    step();
  endtask

  int r, f, s0, n0;
  logic [31:0] x, y;
  int exp_own[4];

  initial begin
    reset = 1; wr_req = 0; rd_req = 0;
    wr_din = 0; rd_din = 0;
    core_initializing = 0; core_busy = 0; core_dout = 0;
    busy_left = 0; stuck = 0; res_pend = 0; fix_n = -1;
    wr_mode = 0; rd_mode = 0; rand_init = 0;
    m_idle = 1; m_op = 0; m_own = 0; m_to = 0; m_last = 1;
    m_err = 0; m_done_k = -10; m_din = 0;
    m_wdout = 0; m_rdout = 0; cur_n = 0;
    k = 0; start_k = -1000; wr_done_k = -1000; rd_done_k = -1000;
    wr_done_n = 0; rd_done_n = 0;

    do_reset();
    chk("rst_core_start", core_start, 0);
    chk("rst_core_decrypt", core_decrypt, 0);
    chk("rst_core_din", core_din, 0);
    chk("rst_wr_dout", wr_dout, 0);
    chk("rst_rd_dout", rd_dout, 0);

    // 1: single store op, 3 busy cycles
    fix_n = 3;
    wr_din = 32'h1234_5678; wr_req = 1; r = k;
    repeat (8) step();
    chk("t1_start_lat", start_k - r, 1);
    chk("t1_done_lat", wr_done_k - r, 6);
    chk("t1_wr_dout", wr_dout, 32'hCAFE_0001);

    // 2: both sides requesting continuously
    do_reset();
    fix_n = 1; owner_log.delete();
    wr_mode = 1; rd_mode = 1;
    repeat (30) step();
    wr_mode = 0; rd_mode = 0;
    repeat (20) step();
`ifdef DATA_MEM_RD_PRIORITY_EN
    exp_own = '{1, 1, 1, 1};
`else
    exp_own = '{0, 1, 0, 1};
`endif
    chk("t2_ops", owner_log.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_grant%0d", i),
          (i < owner_log.size()) ? owner_log[i] : 9,
          exp_own[i]);

    // 3: key schedule holds off grants
    fix_n = 2;
    core_initializing = 1; rd_req = 1; rd_din = $urandom;
    s0 = start_k;
    repeat (10) step();
    chk("t3_no_start", start_k, s0);
    core_initializing = 0; f = k;
    repeat (10) step();
    chk("t3_start_lat", start_k - f, 1);

    // 4: stuck core -> watchdog
    stuck = 1; n0 = wr_done_n;
    wr_req = 1; wr_din = $urandom; r = k;
    repeat (12) step();
    chk("t4_err", timeout_err, 1);
    chk("t4_done_lat", wr_done_k - r, TO + 2);
    chk("t4_done_once", wr_done_n - n0, 1);
    stuck = 0; busy_left = 0; fix_n = 2;
    rd_req = 1; rd_din = $urandom;
    repeat (8) step();
    chk("t4_err_sticky", timeout_err, 1);

    // 5: reset during WAIT
    do_reset();
    fix_n = 3; n0 = rd_done_n;
    rd_req = 1; rd_din = $urandom;
    repeat (3) step();
    reset = 1; rd_req = 0; busy_left = 0;
    step();
    reset = 0;
    chk("t5_core_start", core_start, 0);
    chk("t5_core_din", core_din, 0);
    chk("t5_core_decrypt", core_decrypt, 0);
    chk("t5_rd_done", rd_done, 0);
    chk("t5_err", timeout_err, 0);
    repeat (5) step();
    chk("t5_no_done", rd_done_n - n0, 0);
    wr_req = 1; wr_din = $urandom; r = k;
    repeat (8) step();
    chk("t5_fresh_done", wr_done_k - r, 6);

    // 6: store arrives during a load op
    x = $urandom; y = $urandom;
    rd_req = 1; rd_din = x; r = k;
    repeat (3) step();
    wr_req = 1; wr_din = y;
    repeat (12) step();
    chk("t6_rd_done", rd_done_k - r, 6);
    chk("t6_wr_start", start_k - r, 8);
    chk("t6_rd_dout", rd_dout, x ^ KD);
    chk("t6_wr_dout", wr_dout, y ^ KE);

    // random traffic
    do_reset();
    fix_n = -1; wr_mode = 2; rd_mode = 2; rand_init = 1;
    repeat (3000) step();
    wr_mode = 0; rd_mode = 0; rand_init = 0;
    core_initializing = 0;
    repeat (30) step();
    chk("rand_drained", wr_req | rd_req, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
